// File: rtl/alu_issue_stage_pkg.sv
// Opcode encoding shared by the issue stage, the ALU and the bench so
// that all three agree on what each 3-bit opcode means.
package alu_issue_stage_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_PASS = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_issue_stage.sv
// Two-stage valid/ready wrapper around an external combinational ALU:
// stage 1 registers the command and drives the ALU, stage 2 registers the result.
import alu_issue_stage_pkg::*;

module alu_issue_stage #(
  parameter int N     = 16,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [OP_W-1:0]  in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [N-1:0]     alu_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic [CNT_W-1:0] op_count
);

  logic             s1_valid;
  logic [N-1:0]     s1_a;
  logic [N-1:0]     s1_b;
  logic [OP_W-1:0]  s1_op;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_valid;
  logic [N-1:0]     s2_y;
  logic [TAG_W-1:0] s2_tag;
  logic             s2_zero;

  logic s2_free;
  logic s1_adv;
  logic in_fire;
  logic out_fire;

  // in_ready depends only on registered state and out_ready, never on in_valid.
  assign s2_free  = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !s1_valid || s2_free;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid && out_ready;

  // Operand registers only load on accept, so the ALU inputs stay quiet when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
      s1_tag   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_op    <= in_op;
      s1_tag   <= in_tag;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_tag   <= '0;
      s2_zero  <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_y     <= alu_y;
      s2_tag   <= s1_tag;
      s2_zero  <= (alu_y == '0);
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (out_fire) begin
      op_count <= op_count + 1'b1;
    end
  end

  assign alu_a     = s1_a;
  assign alu_b     = s1_b;
  assign alu_op    = s1_op;
  assign out_valid = s2_valid;
  assign out_y     = s2_y;
  assign out_tag   = s2_tag;
  assign out_zero  = s2_zero;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench: vector table, directed corner sequences and a random
// phase, all checked against a queue-based model of an in-order 2-deep pipe.
import alu_issue_stage_pkg::*;

module tb_alu_issue_stage;

  localparam int N     = 16;
  localparam int TAG_W = 4;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic [2:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic [N-1:0]     alu_a;
  logic [N-1:0]     alu_b;
  logic [2:0]       alu_op;
  logic [N-1:0]     alu_y;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_y;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;
  logic [CNT_W-1:0] op_count;

  alu_issue_stage #(.N(N), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_tag(out_tag), .out_zero(out_zero),
    .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] alu_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [2:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SHL:  return a << b[3:0];
      OP_SHR:  return a >> b[3:0];
      default: return a;
    endcase
  endfunction

  // Stand-in for the attached combinational ALU.
  always_comb alu_y = alu_model(alu_a, alu_b, alu_op);

  typedef struct packed {
    logic [N-1:0]     y;
    logic [TAG_W-1:0] tag;
  } sb_t;

  typedef struct {
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
    logic [N-1:0]     y;
    bit               z;
  } vec_t;

  sb_t              q[$];
  logic [CNT_W-1:0] model_cnt;
  bit               last_acc;
  int               compared;
  int               mismatched;
  int               ov_seen;
  int               ir_low;
  int               dut_acc;
  vec_t             vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Oldest in-flight command sits in stage 2 unless it was accepted on the last edge.
  function automatic bit ov_exp();
    return (q.size() > 0) && !(q.size() == 1 && last_acc);
  endfunction

  task automatic cycle(input bit v, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [2:0] op, input logic [TAG_W-1:0] tag, input bit rdy);
    bit exp_ov;
    bit exp_ir;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    in_tag    = tag;
    out_ready = rdy;
    #1;
    exp_ov = ov_exp();
    exp_ir = (q.size() < 2) || rdy;
    check("out_valid", out_valid, exp_ov);
    check("in_ready", in_ready, exp_ir);
    check("op_count", op_count, model_cnt);
    if (exp_ov && out_valid) begin
      check("out_y", out_y, q[0].y);
      check("out_tag", out_tag, q[0].tag);
      check("out_zero", out_zero, q[0].y == '0);
    end
    if (out_valid) ov_seen++;
    if (!in_ready) ir_low++;
    if (v && in_ready) dut_acc++;
    @(posedge clk);
    if (exp_ov && rdy) begin
      void'(q.pop_front());
      model_cnt = model_cnt + 1'b1;
    end
    if (v && exp_ir) q.push_back('{alu_model(a, b, op), tag});
    last_acc = v && exp_ir;
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, '0, '0, 3'b000, '0, rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && q.size() > 0; i++) idle(1'b1);
    check("drained", q.size(), 0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    model_cnt  = '0;
    last_acc   = 1'b0;
    ov_seen    = 0;
    ir_low     = 0;
    dut_acc    = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    in_b       = '0;
    in_op      = '0;
    in_tag     = '0;
    out_ready  = 1'b0;

    vecs[0] = '{16'h0003, 16'h0004, OP_ADD,  4'd5, 16'h0007, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, OP_SUB,  4'd1, 16'hFFFF, 1'b0};
    vecs[2] = '{16'hA5A5, 16'hA5A5, OP_XOR,  4'd2, 16'h0000, 1'b1};
    vecs[3] = '{16'hF0F0, 16'hFF00, OP_AND,  4'd3, 16'hF000, 1'b0};
    vecs[4] = '{16'h00F0, 16'h0F00, OP_OR,   4'd4, 16'h0FF0, 1'b0};
    vecs[5] = '{16'h0001, 16'h0004, OP_SHL,  4'd9, 16'h0010, 1'b0};
    vecs[6] = '{16'h8000, 16'h000F, OP_SHR,  4'd6, 16'h0001, 1'b0};
    vecs[7] = '{16'h1234, 16'hBEEF, OP_PASS, 4'd7, 16'h1234, 1'b0};

    // Reset values
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_op_count", op_count, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_zero", out_zero, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: each command goes through an empty pipe
    foreach (vecs[i]) begin
      cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag, 1'b1);
      idle(1'b1);
      check("vec_valid", out_valid, 1);
      check("vec_y", out_y, vecs[i].y);
      check("vec_tag", out_tag, vecs[i].tag);
      check("vec_zero", out_zero, vecs[i].z);
      idle(1'b1);
      check("vec_count", op_count, (i + 1) % 16);
      $display("vector %0d: a=%h b=%h op=%0d -> y=%h tag=%0d", i, vecs[i].a, vecs[i].b,
               vecs[i].op, out_y, out_tag);
    end

    // Streaming at full rate
    ov_seen = 0;
    ir_low  = 0;
    for (int i = 0; i < 8; i++)
      cycle(1'b1, 16'($urandom), 16'($urandom), 3'($urandom), 4'(i), 1'b1);
    idle(1'b1);
    idle(1'b1);
    check("stream_out_cycles", ov_seen, 8);
    check("stream_in_ready_low", ir_low, 0);
    $display("stream: %0d results, in_ready low %0d cycles", ov_seen, ir_low);

    // Backpressure: only two commands fit while the consumer stalls
    dut_acc = 0;
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 16'($urandom), 16'($urandom), 3'($urandom), 4'(8 + i), 1'b0);
    check("bp_accepted", dut_acc, 2);
    check("bp_in_ready", in_ready, 0);
    drain();
    check("bp_out_valid_after", out_valid, 0);
    $display("backpressure: accepted %0d while stalled", dut_acc);

    // Reset with both stages full
    cycle(1'b1, 16'h1111, 16'h2222, OP_ADD, 4'd1, 1'b0);
    cycle(1'b1, 16'h3333, 16'h4444, OP_SUB, 4'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_op_count", op_count, 0);
    q.delete();
    model_cnt = '0;
    last_acc  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 16'h0010, 16'h0020, OP_ADD, 4'd3, 1'b1);
    idle(1'b1);
    check("post_rst_y", out_y, 16'h0030);
    check("post_rst_tag", out_tag, 3);
    idle(1'b1);
    check("post_rst_count", op_count, 1);
    $display("reset mid-operation: flushed, post-reset add y=0030");

    // Counter wrap 15 -> 0
    for (int i = 0; i < 60 && !(model_cnt == 4'd15 && ov_exp()); i++)
      cycle(1'b1, 16'($urandom), 16'($urandom), 3'($urandom), 4'($urandom), 1'b1);
    check("wrap_pre", op_count, 15);
    idle(1'b1);
    check("wrap_post", op_count, 0);
    drain();
    $display("counter wrap: 15 -> %0d", op_count);

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom),
            3'($urandom), 4'($urandom), 1'($urandom_range(0, 2) != 0));
    drain();
    $display("random: 400 cycles done, op_count=%0d", op_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
